// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchroniser, strobe-sampled stability counter, one-clk
// press/release pulses. Define BUTTON_AUTO_REPEAT_EN to add auto-repeat while held.
module button_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned CNT_W          = 8,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned REPEAT_DELAY   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic debounce_tick,
    input  logic repeat_tick,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [1:0] StRel   = 2'd0;
    localparam logic [1:0] StPwait = 2'd1;
    localparam logic [1:0] StPrs   = 2'd2;
    localparam logic [1:0] StRwait = 2'd3;

    localparam logic             RelRaw  = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] StableN = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             sync1_q, sync2_q, tick_q;
    logic             btn_s, sample_en;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // tick_q resets high so a tick already high at reset release is not a strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RelRaw;
            sync2_q <= RelRaw;
            tick_q  <= 1'b1;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            tick_q  <= debounce_tick;
        end
    end

    assign btn_s     = sync2_q ^ RelRaw;
    assign sample_en = debounce_tick & ~tick_q;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [7:0] RepN = 8'(REPEAT_DELAY);

    logic       rtick_q, rep_edge;
    logic [7:0] rep_q, rep_d;

    assign rep_edge = repeat_tick & ~rtick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rtick_q <= 1'b1;
            rep_q   <= '0;
        end else begin
            rtick_q <= repeat_tick;
            rep_q   <= rep_d;
        end
    end
`else
    logic unused_repeat_tick;
    assign unused_repeat_tick = repeat_tick;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_en) begin
            case (state_q)
                StRel: begin
                    if (btn_s) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = StPrs;
                            press_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StPwait;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StPwait: begin
                    if (!btn_s) begin
                        state_d = StRel;
                        cnt_d   = '0;
                    end else if (cnt_inc == StableN) begin
                        state_d = StPrs;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StPrs: begin
                    if (!btn_s) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d   = StRel;
                            release_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            state_d = StRwait;
                            cnt_d   = CntOne;
                        end
                    end
                end
                default: begin
                    if (btn_s) begin
                        state_d = StPrs;
                        cnt_d   = '0;
                    end else if (cnt_inc == StableN) begin
                        state_d   = StRel;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end

`ifdef BUTTON_AUTO_REPEAT_EN
        // Fresh press clears the repeat count; an aborted release wait resumes it
        rep_d = rep_q;
        if (press_d) begin
            rep_d = '0;
        end else if (state_q == StPrs && state_d == StPrs && rep_edge) begin
            if (rep_q < RepN) begin
                rep_d = rep_q + 8'd1;
            end else begin
                press_d = 1'b1;
            end
        end
`endif

        level_d = (state_d == StPrs) || (state_d == StRwait);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRel;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
